uart_rx_byte: RTL and testbench

//   Serial-to-parallel front end for the nibble-swap datapath.

---
 rtl/uart_rx_byte.sv | 192 +++++++++++++++++++
 tb/tb_uart_rx_byte.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: oversampled async-serial receiver for the nibble-swap datapath.
// Takes 8N1 frames on rx_in, sampled by clk at CLKS_PER_BIT cycles per bit.
// Each good byte is presented on rx_data with a one-cycle rx_valid strobe.
// Optional feature macro: UART_PARITY_EN.
// When it is defined, the frame becomes 8E1 and the rx_parity_err port is added.
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err,
  output logic       rx_busy
`ifdef UART_PARITY_EN
  ,
  output logic       rx_parity_err
`endif
);

  localparam int CNT_W = (CLKS_PER_BIT <= 2) ? 1 : $clog2(CLKS_PER_BIT);

  // The start bit is checked half a bit in, so every later sample lands mid-bit.
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  state_t state, state_next;

  logic             sync_1, sync_2;
  logic             rx_s;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [2:0]       bit_idx, bit_idx_next;
  logic [7:0]       shift, shift_next;
  logic [7:0]       data_next;
  logic             valid_next;
  logic             frame_err_next;

`ifdef UART_PARITY_EN
  logic             par_bit, par_bit_next;
  logic             parity_err_next;
`endif

  assign rx_s    = sync_2;
  assign rx_busy = (state != S_IDLE);

  // Two-flop synchronizer. The reset value of 1 matches an idle line.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_1 <= 1'b1;
      sync_2 <= 1'b1;
    end else begin
      sync_1 <= rx_in;
      sync_2 <= sync_1;
    end
  end

  // State register, plus the datapath and strobe registers that the FSM steers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      cnt          <= '0;
      bit_idx      <= '0;
      shift        <= '0;
      rx_data      <= 8'h00;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
`ifdef UART_PARITY_EN
      par_bit       <= 1'b0;
      rx_parity_err <= 1'b0;
`endif
    end else begin
      state        <= state_next;
      cnt          <= cnt_next;
      bit_idx      <= bit_idx_next;
      shift        <= shift_next;
      rx_data      <= data_next;
      rx_valid     <= valid_next;
      rx_frame_err <= frame_err_next;
`ifdef UART_PARITY_EN
      par_bit       <= par_bit_next;
      rx_parity_err <= parity_err_next;
`endif
    end
  end

  // Next-state and datapath logic. Strobes default low, and every register holds unless a state moves it.
  always_comb begin
    state_next     = state;
    cnt_next       = cnt + CNT_W'(1);
    bit_idx_next   = bit_idx;
    shift_next     = shift;
    data_next      = rx_data;
    valid_next     = 1'b0;
    frame_err_next = 1'b0;
`ifdef UART_PARITY_EN
    par_bit_next    = par_bit;
    parity_err_next = 1'b0;
`endif

    case (state)
      S_IDLE: begin
        cnt_next = '0;
        if (!rx_s) begin
          state_next = S_START;
        end
      end

      S_START: begin
        if (cnt == HALF_LAST) begin
          cnt_next = '0;
          if (!rx_s) begin
            state_next   = S_DATA;
            bit_idx_next = 3'd0;
          end else begin
            state_next = S_IDLE;
          end
        end
      end

      S_DATA: begin
        if (cnt == FULL_LAST) begin
          cnt_next     = '0;
          shift_next   = {rx_s, shift[7:1]};
          bit_idx_next = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
`ifdef UART_PARITY_EN
            state_next = S_PARITY;
`else
            state_next = S_STOP;
`endif
          end
        end
      end

`ifdef UART_PARITY_EN
      S_PARITY: begin
        if (cnt == FULL_LAST) begin
          cnt_next     = '0;
          par_bit_next = rx_s;
          state_next   = S_STOP;
        end
      end
`endif

      S_STOP: begin
        if (cnt == FULL_LAST) begin
          cnt_next = '0;
          if (rx_s) begin
            state_next = S_IDLE;
`ifdef UART_PARITY_EN
            if ((^shift) != par_bit) begin
              parity_err_next = 1'b1;
            end else begin
              data_next  = shift;
              valid_next = 1'b1;
            end
`else
            data_next  = shift;
            valid_next = 1'b1;
`endif
          end else begin
            frame_err_next = 1'b1;
            state_next     = S_BREAK;
          end
        end
      end

      S_BREAK: begin
        cnt_next = '0;
        if (rx_s) begin
          state_next = S_IDLE;
        end
      end

      default: begin
        cnt_next   = '0;
        state_next = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_rx_byte.sv
// tb_uart_rx_byte: self-checking bench for uart_rx_byte.
// A negedge monitor logs every strobe. Each test sends serial frames and
// compares the logged events against the bytes and cycle times that the
// frame format implies.
module tb_uart_rx_byte;

  localparam int N = 16;
`ifdef UART_PARITY_EN
  localparam int FRAME_BITS = 10;
`else
  localparam int FRAME_BITS = 9;
`endif
  localparam int SYNC_DELAY = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_in;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;
  logic       rx_busy;
`ifdef UART_PARITY_EN
  logic       rx_parity_err;
`endif

  uart_rx_byte #(.CLKS_PER_BIT(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_in        (rx_in),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_frame_err (rx_frame_err),
    .rx_busy      (rx_busy)
`ifdef UART_PARITY_EN
    ,
    .rx_parity_err(rx_parity_err)
`endif
  );

  // Free-running clock.
  always #5 clk = ~clk;

  int cyc = 0;

  // Cycle counter used to timestamp events.
  always @(posedge clk) cyc <= cyc + 1;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] valid_data_q[$];
  int         valid_cyc_q[$];
  int         ferr_cnt = 0;
  int         perr_cnt = 0;
  int         overlap_cnt = 0;
  logic [7:0] last_byte;

  // Monitor: logs each strobe half a cycle away from the active edge.
  always @(negedge clk) begin
    if (rx_valid === 1'b1) begin
      valid_data_q.push_back(rx_data);
      valid_cyc_q.push_back(cyc);
    end
    if (rx_frame_err === 1'b1) ferr_cnt++;
    if (rx_valid === 1'b1 && rx_frame_err === 1'b1) overlap_cnt++;
`ifdef UART_PARITY_EN
    if (rx_parity_err === 1'b1) perr_cnt++;
    if (rx_valid === 1'b1 && rx_parity_err === 1'b1) overlap_cnt++;
`endif
  end

  // Watchdog: guarantees that the run ends on its own.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "[TB] timeout");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    valid_data_q.delete();
    valid_cyc_q.delete();
    ferr_cnt = 0;
    perr_cnt = 0;
  endtask

  task automatic send_bit(input logic b);
    rx_in = b;
    tick(N);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_val, input logic par_flip);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_PARITY_EN
    send_bit((^d) ^ par_flip);
`endif
    send_bit(stop_val);
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    rx_in = 1'b1;
    tick(2);
    checks++;
    if (rx_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_data got %h expected 00", rx_data); end
    checks++;
    if (rx_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b expected 0", rx_valid); end
    checks++;
    if (rx_frame_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_ferr got %b expected 0", rx_frame_err); end
    checks++;
    if (rx_busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b expected 0", rx_busy); end
`ifdef UART_PARITY_EN
    checks++;
    if (rx_parity_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_perr got %b expected 0", rx_parity_err); end
`endif
    rst = 1'b0;
    tick(2);
  endtask

  task automatic test_single_frame();
    int start;
    int exp_cyc;
    clear_mon();
    start   = cyc;
    exp_cyc = start + SYNC_DELAY + N / 2 + FRAME_BITS * N + 1;
    send_frame(8'hA5, 1'b1, 1'b0);
    tick(N);
    checks++;
    if (valid_data_q.size() != 1) begin
      errors++; $display("[TB] FAIL a5_count got %0d expected 1", valid_data_q.size());
    end else begin
      checks++;
      if (valid_data_q[0] !== 8'hA5) begin errors++; $display("[TB] FAIL a5_data got %h expected a5", valid_data_q[0]); end
      checks++;
      if (valid_cyc_q[0] != exp_cyc) begin errors++; $display("[TB] FAIL a5_latency got %0d expected %0d", valid_cyc_q[0] - start, exp_cyc - start); end
    end
    checks++;
    if ({rx_data[3:0], rx_data[7:4]} !== 8'h5A) begin errors++; $display("[TB] FAIL a5_swap got %h expected 5a", {rx_data[3:0], rx_data[7:4]}); end
    checks++;
    if (rx_busy !== 1'b0 || ferr_cnt != 0) begin errors++; $display("[TB] FAIL a5_idle got busy=%b ferr=%0d expected 0/0", rx_busy, ferr_cnt); end
    last_byte = 8'hA5;
  endtask

  task automatic test_glitch();
    clear_mon();
    rx_in = 1'b0;
    tick(4);
    rx_in = 1'b1;
    checks++;
    if (rx_busy !== 1'b1) begin errors++; $display("[TB] FAIL glitch_busy_hi got %b expected 1", rx_busy); end
    tick(7);
    checks++;
    if (rx_busy !== 1'b0) begin errors++; $display("[TB] FAIL glitch_busy_lo got %b expected 0", rx_busy); end
    tick(2 * N);
    checks++;
    if (valid_data_q.size() != 0 || ferr_cnt != 0) begin
      errors++; $display("[TB] FAIL glitch_strobes got valid=%0d ferr=%0d expected 0/0", valid_data_q.size(), ferr_cnt);
    end
  endtask

  task automatic test_frame_error();
    clear_mon();
    send_frame(8'h3C, 1'b0, 1'b0);
    tick(3 * N);
    checks++;
    if (ferr_cnt != 1) begin errors++; $display("[TB] FAIL ferr_count got %0d expected 1", ferr_cnt); end
    checks++;
    if (valid_data_q.size() != 0) begin errors++; $display("[TB] FAIL ferr_valid got %0d expected 0", valid_data_q.size()); end
    checks++;
    if (rx_data !== last_byte) begin errors++; $display("[TB] FAIL ferr_data got %h expected %h", rx_data, last_byte); end
    checks++;
    if (rx_busy !== 1'b1) begin errors++; $display("[TB] FAIL break_busy got %b expected 1", rx_busy); end
    rx_in = 1'b1;
    tick(4);
    checks++;
    if (rx_busy !== 1'b0) begin errors++; $display("[TB] FAIL break_exit got %b expected 0", rx_busy); end
    clear_mon();
    send_frame(8'h81, 1'b1, 1'b0);
    tick(N);
    checks++;
    if (valid_data_q.size() != 1 || valid_data_q[0] !== 8'h81) begin
      errors++; $display("[TB] FAIL after_break got count=%0d data=%h expected 1/81", valid_data_q.size(), rx_data);
    end
    last_byte = 8'h81;
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d;
    d = 8'h0F;
    clear_mon();
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(d[i]);
    rx_in = d[3];
    tick(N / 2);
    rst = 1'b1;
    tick(1);
    checks++;
    if (rx_busy !== 1'b0 || rx_data !== 8'h00 || rx_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL midreset_out got busy=%b data=%h valid=%b expected 0/00/0", rx_busy, rx_data, rx_valid);
    end
    rx_in = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(3 * N);
    checks++;
    if (valid_data_q.size() != 0 || ferr_cnt != 0) begin
      errors++; $display("[TB] FAIL midreset_strobes got valid=%0d ferr=%0d expected 0/0", valid_data_q.size(), ferr_cnt);
    end
    send_frame(d, 1'b1, 1'b0);
    tick(N);
    checks++;
    if (valid_data_q.size() != 1 || rx_data !== 8'h0F) begin
      errors++; $display("[TB] FAIL midreset_next got count=%0d data=%h expected 1/0f", valid_data_q.size(), rx_data);
    end
    last_byte = 8'h0F;
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_q[$];
    logic [7:0] b;
    int gap;
    clear_mon();
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    tick(N);
    checks++;
    if (valid_data_q.size() != 2) begin
      errors++; $display("[TB] FAIL b2b_count got %0d expected 2", valid_data_q.size());
    end else begin
      checks++;
      if (valid_data_q[0] !== 8'h00 || valid_data_q[1] !== 8'hFF) begin
        errors++; $display("[TB] FAIL b2b_data got %h,%h expected 00,ff", valid_data_q[0], valid_data_q[1]);
      end
      checks++;
      if (valid_cyc_q[1] - valid_cyc_q[0] != (FRAME_BITS + 1) * N) begin
        errors++; $display("[TB] FAIL b2b_spacing got %0d expected %0d", valid_cyc_q[1] - valid_cyc_q[0], (FRAME_BITS + 1) * N);
      end
    end
    // Random burst: random bytes separated by random idle gaps, sometimes none.
    clear_mon();
    for (int i = 0; i < 10; i++) begin
      b   = 8'($urandom_range(0, 255));
      gap = (i % 3 == 0) ? 0 : int'($urandom_range(0, N));
      exp_q.push_back(b);
      send_frame(b, 1'b1, 1'b0);
      if (gap > 0) begin
        rx_in = 1'b1;
        tick(gap);
      end
    end
    tick(N);
    checks++;
    if (valid_data_q.size() != exp_q.size()) begin
      errors++; $display("[TB] FAIL rand_count got %0d expected %0d", valid_data_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (valid_data_q[i] !== exp_q[i]) begin
          errors++; $display("[TB] FAIL rand_data[%0d] got %h expected %h", i, valid_data_q[i], exp_q[i]);
        end
      end
    end
    checks++;
    if (rx_data !== exp_q[exp_q.size() - 1] || ferr_cnt != 0) begin
      errors++; $display("[TB] FAIL rand_final got data=%h ferr=%0d expected %h/0", rx_data, ferr_cnt, exp_q[exp_q.size() - 1]);
    end
    last_byte = exp_q[exp_q.size() - 1];
  endtask

`ifdef UART_PARITY_EN
  task automatic test_parity();
    clear_mon();
    send_frame(8'h01, 1'b1, 1'b1);
    tick(N);
    checks++;
    if (perr_cnt != 1 || valid_data_q.size() != 0) begin
      errors++; $display("[TB] FAIL parity_err got perr=%0d valid=%0d expected 1/0", perr_cnt, valid_data_q.size());
    end
    checks++;
    if (rx_data !== last_byte) begin errors++; $display("[TB] FAIL parity_data got %h expected %h", rx_data, last_byte); end
    clear_mon();
    send_frame(8'h01, 1'b0, 1'b1);
    rx_in = 1'b1;
    tick(N);
    checks++;
    if (ferr_cnt != 1 || perr_cnt != 0 || valid_data_q.size() != 0) begin
      errors++; $display("[TB] FAIL parity_stoplow got ferr=%0d perr=%0d valid=%0d expected 1/0/0", ferr_cnt, perr_cnt, valid_data_q.size());
    end
  endtask
`endif

  // Test sequence.
  initial begin
    rst   = 1'b1;
    rx_in = 1'b1;
    tick(1);
    test_reset();
    test_single_frame();
    test_glitch();
    test_frame_error();
    test_reset_mid_frame();
    test_back_to_back();
`ifdef UART_PARITY_EN
    test_parity();
`endif
    checks++;
    if (overlap_cnt != 0) begin errors++; $display("[TB] FAIL strobe_overlap got %0d expected 0", overlap_cnt); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
